// File: rtl/alu_arbiter_if.sv
// Requester, shared-ALU and response signals of the two-port ALU arbiter.
// The arbiter binds the slave modport; the environment binds the master modport.
interface alu_arbiter_if #(
  parameter int XLEN = 32
);
  logic            req0_valid;
  logic            req0_ready;
  logic [3:0]      req0_op;
  logic [XLEN-1:0] req0_a;
  logic [XLEN-1:0] req0_b;
  logic            req1_valid;
  logic            req1_ready;
  logic [3:0]      req1_op;
  logic [XLEN-1:0] req1_a;
  logic [XLEN-1:0] req1_b;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [XLEN-1:0] rsp_result;
  logic            rsp_zero;
  logic            rsp_err;
  logic            busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_result, alu_zero, rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_control,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_result, alu_zero, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_control,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// one operation in flight: IDLE (grant) -> ISSUE (drive ALU) -> RESP (hold result).
module alu_arbiter #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state;
  logic            rr_ptr;
  logic [3:0]      ctl_p0;
  logic [XLEN-1:0] a_p0;
  logic [XLEN-1:0] b_p0;
  logic            id_p0;
  logic            err_p0;

  logic            rsp_valid_q;
  logic            rsp_id_q;
  logic [XLEN-1:0] rsp_result_q;
  logic            rsp_zero_q;
  logic            rsp_err_q;
  logic            busy_q;

  logic            grant0;
  logic            grant1;
  logic [3:0]      sel_op;
  logic [XLEN-1:0] sel_a;
  logic [XLEN-1:0] sel_b;

  function automatic logic op_illegal(input logic [3:0] op);
    return op > 4'd9;
  endfunction

  // Grant is combinational in IDLE; the pointer only breaks ties.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && state == IDLE) begin
      if (bus.req0_valid && (!bus.req1_valid || !rr_ptr))
        grant0 = 1'b1;
      else if (bus.req1_valid)
        grant1 = 1'b1;
    end
  end

  always_comb begin
    sel_op = bus.req0_op;
    sel_a  = bus.req0_a;
    sel_b  = bus.req0_b;
    if (grant1) begin
      sel_op = bus.req1_op;
      sel_a  = bus.req1_a;
      sel_b  = bus.req1_b;
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.alu_a       = a_p0;
  assign bus.alu_b       = b_p0;
  assign bus.alu_control = ctl_p0;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_zero    = rsp_zero_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.busy        = busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= 1'b0;
      ctl_p0       <= '0;
      a_p0         <= '0;
      b_p0         <= '0;
      id_p0        <= 1'b0;
      err_p0       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        // p0: latch the granted request; illegal ops still drive code 0
        IDLE: begin
          if (grant0 || grant1) begin
            ctl_p0 <= op_illegal(sel_op) ? 4'd0 : sel_op;
            err_p0 <= op_illegal(sel_op);
            a_p0   <= sel_a;
            b_p0   <= sel_b;
            id_p0  <= grant1;
            rr_ptr <= grant0;
            busy_q <= 1'b1;
            state  <= ISSUE;
          end
        end
        // p1: capture the shared ALU output into the response registers
        ISSUE: begin
          rsp_result_q <= err_p0 ? '0 : bus.alu_result;
          rsp_zero_q   <= err_p0 | bus.alu_zero;
          rsp_err_q    <= err_p0;
          rsp_id_q     <= id_p0;
          rsp_valid_q  <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter with a behavioural ALU and
// an abstract model of grants, ownership and response timing.
module tb_alu_arbiter;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.XLEN(32)) bus ();

  alu_arbiter #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  exp_t        sb[$];
  int          glog[$];
  int          gcnt[2];
  bit          outstanding = 0;
  int          age = 0;
  bit          exp_ptr = 0;
  logic [31:0] h_a = '0;
  logic [31:0] h_b = '0;
  logic [3:0]  h_ctl = '0;

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: return a << b[4:0];
      4'd8: return a >> b[4:0];
      4'd9: return sa >>> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  // Shared combinational ALU
  assign bus.alu_result = alu_ref(bus.alu_control, bus.alu_a, bus.alu_b);
  assign bus.alu_zero   = (bus.alu_result == 32'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t expect_of(input logic id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.id   = id;
    e.err  = (op > 4'd9);
    e.res  = e.err ? 32'd0 : alu_ref(op, a, b);
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Monitor and scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    bit   e0, e1;
    exp_t f;
    if (!rst_n) begin
      chk("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
      chk("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
      sb.delete();
      outstanding = 0;
      age = 0;
      exp_ptr = 0;
      h_a = '0;
      h_b = '0;
      h_ctl = '0;
    end else begin
      e0 = !outstanding && bus.req0_valid && (!bus.req1_valid || !exp_ptr);
      e1 = !outstanding && bus.req1_valid && !e0;
      chk("ready0", {31'd0, bus.req0_ready}, {31'd0, e0});
      chk("ready1", {31'd0, bus.req1_ready}, {31'd0, e1});
      chk("busy", {31'd0, bus.busy}, {31'd0, outstanding});
      if (outstanding) age++;
      chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, (outstanding && age >= 2)});
      chk("alu_a", bus.alu_a, h_a);
      chk("alu_b", bus.alu_b, h_b);
      chk("alu_control", {28'd0, bus.alu_control}, {28'd0, h_ctl});
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp actual=valid required=none t=%0t", $time);
        end else begin
          f = sb[0];
          chk("rsp_id", {31'd0, bus.rsp_id}, {31'd0, f.id});
          chk("rsp_result", bus.rsp_result, f.res);
          chk("rsp_zero", {31'd0, bus.rsp_zero}, {31'd0, f.zero});
          chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, f.err});
          if (bus.rsp_ready && outstanding && age >= 2) begin
            void'(sb.pop_front());
            outstanding = 0;
          end
        end
      end
      if (e0 || e1) begin
        if (e0) begin
          sb.push_back(expect_of(1'b0, bus.req0_op, bus.req0_a, bus.req0_b));
          h_a = bus.req0_a; h_b = bus.req0_b;
          h_ctl = (bus.req0_op > 4'd9) ? 4'd0 : bus.req0_op;
        end else begin
          sb.push_back(expect_of(1'b1, bus.req1_op, bus.req1_a, bus.req1_b));
          h_a = bus.req1_a; h_b = bus.req1_b;
          h_ctl = (bus.req1_op > 4'd9) ? 4'd0 : bus.req1_op;
        end
        outstanding = 1;
        age = 0;
        exp_ptr = e0;
        gcnt[e1 ? 1 : 0]++;
        glog.push_back(e1 ? 1 : 0);
      end
    end
  end

  task automatic set_req(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (k == 0) begin
      bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
    end
  endtask

  task automatic drop_req(input int k);
    if (k == 0) bus.req0_valid = 1'b0;
    else        bus.req1_valid = 1'b0;
  endtask

  // Returns #1 after the edge that accepted requester k, then drops its valid
  task automatic wait_grant(input int k);
    int start;
    start = gcnt[k];
    for (int i = 0; i < 60 && gcnt[k] == start; i++) @(posedge clk);
    #1;
    if (gcnt[k] == start) begin
      checks++;
      failures++;
      $display("FAIL grant_timeout actual=none required=grant%0d", k);
    end
    drop_req(k);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && (outstanding || sb.size() != 0); i++) @(posedge clk);
    #1;
    if (outstanding || sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_rsp_misc", {29'd0, bus.rsp_id, bus.rsp_zero, bus.rsp_err}, 32'd0);
    chk("rst_rsp_result", bus.rsp_result, 32'd0);
    chk("rst_alu", {bus.alu_a | bus.alu_b}, 32'd0);
    chk("rst_alu_control", {28'd0, bus.alu_control}, 32'd0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    int s0, s1, seen0, seen1;
    bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.rsp_ready = 1'b1;
    gcnt[0] = 0;
    gcnt[1] = 0;
    do_reset();

    // Single ADD from requester 0
    set_req(0, 4'd0, 32'd5, 32'd7);
    wait_grant(0);
    wait_idle();

    // Both requesters continuously valid: grants alternate from 0
    do_reset();
    glog.delete();
    set_req(0, 4'd0, $urandom, $urandom);
    set_req(1, 4'd1, 32'd3, 32'd3);
    s0 = gcnt[0];
    s1 = gcnt[1];
    for (int c = 0; c < 200 && glog.size() < 8; c++) begin
      @(posedge clk);
      #1;
      if (gcnt[0] != s0) begin s0 = gcnt[0]; set_req(0, 4'($urandom_range(0, 9)), $urandom, $urandom); end
      if (gcnt[1] != s1) begin s1 = gcnt[1]; set_req(1, 4'($urandom_range(0, 9)), $urandom, $urandom); end
    end
    drop_req(0);
    drop_req(1);
    wait_idle();
    chk("alt_count", (glog.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
    chk("alt_g0", 32'(glog[0]), 32'd0);
    chk("alt_g1", 32'(glog[1]), 32'd1);
    chk("alt_g2", 32'(glog[2]), 32'd0);
    chk("alt_g3", 32'(glog[3]), 32'd1);

    // SRA with shift amount from b[4:0]
    set_req(1, 4'd9, 32'h8000_0000, 32'h0000_0024);
    wait_grant(1);
    wait_idle();
    chk("sra_expect", alu_ref(4'd9, 32'h8000_0000, 32'h24), 32'hF800_0000);

    // Illegal op
    set_req(0, 4'hC, $urandom, $urandom);
    wait_grant(0);
    wait_idle();

    // Back-pressure: response held five cycles
    bus.rsp_ready = 1'b0;
    set_req(0, 4'd4, $urandom, $urandom);
    wait_grant(0);
    @(posedge clk);
    #1;
    set_req(1, 4'd3, $urandom, $urandom);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("hold_busy", {31'd0, bus.busy}, 32'd1);
    chk("hold_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("hold_ready1", {31'd0, bus.req1_ready}, 32'd0);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    wait_grant(1);
    wait_idle();

    // Reset during ISSUE discards the operation and clears the pointer
    set_req(0, 4'd1, $urandom, $urandom);
    wait_grant(0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    chk("flush_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    glog.delete();
    set_req(0, 4'd2, $urandom, $urandom);
    set_req(1, 4'd2, $urandom, $urandom);
    wait_grant(0);
    wait_grant(1);
    wait_idle();
    chk("flush_ptr_first", 32'(glog[0]), 32'd0);

    // Randomized traffic with random back-pressure
    seen0 = gcnt[0];
    seen1 = gcnt[1];
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      if (bus.req0_valid && gcnt[0] != seen0) drop_req(0);
      if (bus.req1_valid && gcnt[1] != seen1) drop_req(1);
      seen0 = gcnt[0];
      seen1 = gcnt[1];
      if (!bus.req0_valid && $urandom_range(0, 2) == 0)
        set_req(0, 4'($urandom_range(0, 11)), $urandom, $urandom);
      if (!bus.req1_valid && $urandom_range(0, 2) == 0)
        set_req(1, 4'($urandom_range(0, 11)), $urandom, $urandom);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    drop_req(0);
    drop_req(1);
    bus.rsp_ready = 1'b1;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester 0/1 has an operation pending.
REQ-005 req0_ready / req1_ready  output  1 each  requester 0/1 handshake accepted this cycle.
REQ-006 req0_op / req1_op  input  4 each  ALU control code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  XLEN each  operands.
REQ-008 alu_a, alu_b  output  XLEN each  operands driven to the shared ALU.
REQ-009 alu_control  output  4  control code driven to the shared ALU.
REQ-010 alu_result  input  XLEN  shared ALU result, combinational from alu_a/alu_b/alu_control.
REQ-011 alu_zero  input  1  shared ALU zero flag.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_id  output  1  requester index that owns the response.
REQ-015 rsp_result  output  XLEN  captured result.
REQ-016 rsp_zero  output  1  captured zero flag.
REQ-017 rsp_err  output  1  op code was illegal (greater than 9).
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, RESP; exactly one operation outstanding at a time.
REQ-020 In IDLE, req_ready SHALL be asserted combinationally for exactly one valid requester; both ready SHALL be low in ISSUE and RESP.
REQ-021 With a single valid requester in IDLE, that requester SHALL be granted.
REQ-022 With both requesters valid in IDLE, the requester selected by the round-robin pointer SHALL be granted.
REQ-023 After every grant, the pointer SHALL point to the non-granted index; the pointer SHALL NOT change in cycles with no grant.
REQ-024 On grant (valid and ready high), the block SHALL latch op, a, b and id, then move IDLE->ISSUE.
REQ-025 In ISSUE, alu_a, alu_b and alu_control SHALL come from the latched values.
REQ-026 At the end of ISSUE, alu_result and alu_zero SHALL be captured into rsp_result and rsp_zero, and the FSM SHALL move ISSUE->RESP.
REQ-027 Latency: a grant in cycle N SHALL give rsp_valid high in cycle N+2.
REQ-028 Outside ISSUE, alu_a, alu_b and alu_control SHALL hold the last latched values (no glitch-driven toggling).
REQ-029 Illegal op (greater than 9): ISSUE still occurs with alu_control forced to 0; the response SHALL carry rsp_result=0, rsp_zero=1, rsp_err=1.
REQ-030 In RESP, rsp_valid SHALL stay high and rsp_* SHALL stay stable until rsp_ready is high.
REQ-031 When rsp_valid and rsp_ready are both high, the FSM SHALL move RESP->IDLE; a new grant is possible in the following cycle at the earliest, so throughput is at most one op per 3 cycles.
REQ-032 Requesters SHALL hold valid and operands stable until ready; a requester dropping valid before grant is not an error and is simply not granted.
REQ-033 Signed and shift semantics SHALL be the ALU's: SLT signed, SLTU unsigned, shift amount b[4:0], SRA arithmetic.

Reset
REQ-034 While rst_n is low at a clk edge: state SHALL go to IDLE, round-robin pointer to 0 (requester 0 preferred), and latched op/a/b/id to 0.
REQ-035 Reset values: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0, busy=0, alu_a=0, alu_b=0, alu_control=0.
REQ-036 A reset asserted in ISSUE or RESP SHALL discard the in-flight operation; no response SHALL follow.
REQ-037 req0_ready and req1_ready SHALL be low during any cycle where rst_n is low.

Verification
REQ-038 req0 ADD a=5, b=7; rsp_ready=1 -> rsp_valid in grant+2, rsp_id=0, result 12, zero=0, err=0.
REQ-039 req0 and req1 both valid continuously, after reset -> grants alternate 0,1,0,1; req1 SUB 3-3 returns result 0, zero=1.
REQ-040 req1 SRA a=0x80000000, b=0x24 -> result 0xF8000000 (shift 4).
REQ-041 req0 op=4'hC -> result 0, zero=1, err=1; FSM returns to IDLE normally.
REQ-042 rsp_ready held low 5 cycles in RESP -> rsp_* stable, both ready low, busy=1; then rsp_ready=1 -> IDLE next cycle.
REQ-043 rst_n low during ISSUE -> next cycle busy=0 and rsp_valid=0, no response, pointer=0.
